// File: rtl/traffic_light_ctrl.sv
// Traffic light sequencer driving the RGB LED color select.
// Prescaled phase timer, four-state FSM, sticky pedestrian latch.
module traffic_light_ctrl #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int RED_TICKS       = 4,
  parameter int GREEN_TICKS     = 6,
  parameter int YELLOW_TICKS    = 2,
  parameter int WALK_TICKS      = 6,
  parameter int MIN_GREEN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       maint,
  output logic [1:0] color,
  output logic       walk,
  output logic       ped_pending
);

  localparam int MAX_RG = (RED_TICKS > GREEN_TICKS) ?
                          RED_TICKS : GREEN_TICKS;
  localparam int MAX_YW = (YELLOW_TICKS > WALK_TICKS) ?
                          YELLOW_TICKS : WALK_TICKS;
  localparam int MAX_T  = (MAX_RG > MAX_YW) ? MAX_RG : MAX_YW;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] R_LAST = TW'(RED_TICKS - 1);
  localparam logic [TW-1:0] W_LAST = TW'(WALK_TICKS - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] M_LAST = TW'(MIN_GREEN_TICKS - 1);

  // Encoding matches the LED color select so color is the state flop.
  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_YELLOW = 2'd1,
    S_GREEN  = 2'd2,
    S_MAINT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [TW-1:0] timer, timer_n;
  logic          walk_n;
  logic          pend_n;
  logic          tick;
  logic [TW-1:0] red_last;

  assign tick     = en && (presc == P_LAST);
  assign red_last = walk ? W_LAST : R_LAST;
  assign color    = state;

  // Next-state, counter and latch logic; maint has priority over timing.
  always_comb begin
    state_n = state;
    presc_n = presc;
    timer_n = timer;
    walk_n  = walk;
    pend_n  = ped_pending | ped_req;
    if (maint) begin
      state_n = S_MAINT;
      presc_n = '0;
      timer_n = '0;
      walk_n  = 1'b0;
      pend_n  = 1'b0;
    end else if (state == S_MAINT) begin
      state_n = S_RED;
      presc_n = '0;
      timer_n = '0;
      walk_n  = 1'b0;
      pend_n  = ped_pending;
    end else if (en) begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) begin
        timer_n = timer + 1'b1;
        case (state)
          S_RED: begin
            if (timer == red_last) begin
              state_n = S_GREEN;
              walk_n  = 1'b0;
            end
          end
          S_GREEN: begin
            if (timer == G_LAST ||
                (ped_pending && timer >= M_LAST))
              state_n = S_YELLOW;
          end
          S_YELLOW: begin
            if (timer == Y_LAST) begin
              state_n = S_RED;
              walk_n  = ped_pending | ped_req;
              pend_n  = 1'b0;
            end
          end
          default: state_n = S_RED;
        endcase
        if (state_n != state)
          timer_n = '0;
      end
    end
  end

  // State, counters and pedestrian latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RED;
      presc       <= '0;
      timer       <= '0;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      timer       <= timer_n;
      walk        <= walk_n;
      ped_pending <= pend_n;
    end
  end

endmodule
